// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
// Arbitrates register-file accesses between port A (serial config) and
// port B (calibration engine). It sequences every access as
// setup -> strobe -> hold and returns an ack/err pulse plus read data to
// the port that owns the access.
//
// Ports
//   clk, reset_n            system clock, async active-low reset
//   a_valid/a_we/a_addr/a_wdata  port A request (held until a_ack)
//   a_ack/a_err/a_rdata     port A completion pulse, error flag, read data
//   b_*                     same as a_*, for port B
//   rf_write_addr/rf_write_data/rf_read_addr  register-file address/data
//   rf_write/rf_read        register-file strobes (registered pulses)
//   rf_read_data            register-file readback data
//   busy                    high whenever the sequencer is not idle
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request; grant and latch it
// SETUP  | address/data driven, strobes low
// STROBE | rf_write or rf_read high
// HOLD   | strobes low, address/data held; read data captured
// RESP   | one-cycle ack (and err) to the granted port
module regfile_access_ctrl #(
  parameter int NUMREGS       = 16,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       a_valid,
  input  logic       a_we,
  input  logic [7:0] a_addr,
  input  logic [7:0] a_wdata,
  output logic       a_ack,
  output logic       a_err,
  output logic [7:0] a_rdata,
  input  logic       b_valid,
  input  logic       b_we,
  input  logic [7:0] b_addr,
  input  logic [7:0] b_wdata,
  output logic       b_ack,
  output logic       b_err,
  output logic [7:0] b_rdata,
  output logic [7:0] rf_write_addr,
  output logic [7:0] rf_write_data,
  output logic [7:0] rf_read_addr,
  output logic       rf_write,
  output logic       rf_read,
  input  logic [7:0] rf_read_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RESP
  } state_t;

  localparam int unsigned NREGS       = NUMREGS;
  localparam logic [7:0]  SETUP_LOAD  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0]  STROBE_LOAD = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0]  HOLD_LOAD   = 8'(HOLD_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;

  logic       r_last_b;   // 1: port B was granted last
  logic       r_gnt_b;    // owner of the access in flight
  logic       r_we;

  logic       r_a_ack, r_a_err, r_b_ack, r_b_err;
  logic [7:0] r_a_rdata, r_b_rdata;
  logic [7:0] r_rf_write_addr, r_rf_write_data, r_rf_read_addr;
  logic       r_rf_write, r_rf_read, r_busy;

  logic       w_grant;
  logic       w_gnt_b;
  logic       w_sel_we;
  logic [7:0] w_sel_addr;
  logic [7:0] w_sel_wdata;
  logic       w_oor;
  logic       w_first_hold;

  // Round robin: B wins a tie only if A was served last.
  assign w_gnt_b     = b_valid && (!a_valid || !r_last_b);
  assign w_sel_we    = w_gnt_b ? b_we    : a_we;
  assign w_sel_addr  = w_gnt_b ? b_addr  : a_addr;
  assign w_sel_wdata = w_gnt_b ? b_wdata : a_wdata;
  assign w_oor       = (32'(w_sel_addr) >= NREGS);
  // Down-counter is loaded with HOLD_CYCLES-1 on entry, so this marks
  // the first HOLD cycle.
  assign w_first_hold = (r_state == S_HOLD) && (r_cnt == HOLD_LOAD);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (a_valid || b_valid) begin
          w_grant = 1'b1;
          if (w_oor) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_SETUP;
            w_cnt_nxt   = SETUP_LOAD;
          end
        end
      end
      S_SETUP: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = S_STROBE;
          w_cnt_nxt   = STROBE_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_STROBE: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = HOLD_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_HOLD: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_cnt           <= 8'd0;
      r_last_b        <= 1'b1;
      r_gnt_b         <= 1'b0;
      r_we            <= 1'b0;
      r_a_ack         <= 1'b0;
      r_a_err         <= 1'b0;
      r_b_ack         <= 1'b0;
      r_b_err         <= 1'b0;
      r_a_rdata       <= 8'd0;
      r_b_rdata       <= 8'd0;
      r_rf_write_addr <= 8'd0;
      r_rf_write_data <= 8'd0;
      r_rf_read_addr  <= 8'd0;
      r_rf_write      <= 1'b0;
      r_rf_read       <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      // STROBE is never entered straight from IDLE, so r_we is already
      // the latched value whenever this term can be true.
      r_rf_write <= (w_state_nxt == S_STROBE) && r_we;
      r_rf_read  <= (w_state_nxt == S_STROBE) && !r_we;
      r_a_ack    <= 1'b0;
      r_a_err    <= 1'b0;
      r_b_ack    <= 1'b0;
      r_b_err    <= 1'b0;

      if (w_grant) begin
        r_last_b <= w_gnt_b;
        r_gnt_b  <= w_gnt_b;
        r_we     <= w_sel_we;
        if (w_oor) begin
          r_a_ack <= !w_gnt_b;
          r_a_err <= !w_gnt_b;
          r_b_ack <= w_gnt_b;
          r_b_err <= w_gnt_b;
          if (!w_sel_we) begin
            if (w_gnt_b) r_b_rdata <= 8'd0;
            else         r_a_rdata <= 8'd0;
          end
        end else if (w_sel_we) begin
          r_rf_write_addr <= w_sel_addr;
          r_rf_write_data <= w_sel_wdata;
        end else begin
          r_rf_read_addr <= w_sel_addr;
        end
      end

      if (w_first_hold && !r_we) begin
        if (r_gnt_b) r_b_rdata <= rf_read_data;
        else         r_a_rdata <= rf_read_data;
      end

      if ((r_state == S_HOLD) && (w_state_nxt == S_RESP)) begin
        r_a_ack <= !r_gnt_b;
        r_b_ack <= r_gnt_b;
      end
    end
  end

  assign a_ack         = r_a_ack;
  assign a_err         = r_a_err;
  assign a_rdata       = r_a_rdata;
  assign b_ack         = r_b_ack;
  assign b_err         = r_b_err;
  assign b_rdata       = r_b_rdata;
  assign rf_write_addr = r_rf_write_addr;
  assign rf_write_data = r_rf_write_data;
  assign rf_read_addr  = r_rf_read_addr;
  assign rf_write      = r_rf_write;
  assign rf_read       = r_rf_read;
  assign busy          = r_busy;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: table-driven single-port accesses,
// hand-written arbitration/reset/timing sequences, and randomized rounds
// checked against a transaction-level model.
module tb_regfile_access_ctrl;

  localparam int S    = 1;
  localparam int T    = 2;
  localparam int H    = 1;
  localparam int NREG = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;

  logic       a_valid = 0, a_we = 0, b_valid = 0, b_we = 0;
  logic [7:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
  logic       a_ack, a_err, b_ack, b_err;
  logic [7:0] a_rdata, b_rdata;
  logic [7:0] rf_write_addr, rf_write_data, rf_read_addr, rf_read_data;
  logic       rf_write, rf_read, busy;

  // second instance with stretched timing, driven on port A only
  logic       p_valid = 0, p_we = 0;
  logic [7:0] p_addr = 0, p_wdata = 0;
  logic       p_ack, p_err, q_b_ack, q_b_err, p_rf_write, p_rf_read, p_busy;
  logic [7:0] p_rdata, q_b_rdata, p_rf_waddr, p_rf_wdata, p_rf_raddr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_access_ctrl u_dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .rf_read_addr(rf_read_addr), .rf_write(rf_write), .rf_read(rf_read),
    .rf_read_data(rf_read_data), .busy(busy)
  );

  regfile_access_ctrl #(.NUMREGS(16), .SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n),
    .a_valid(p_valid), .a_we(p_we), .a_addr(p_addr), .a_wdata(p_wdata),
    .a_ack(p_ack), .a_err(p_err), .a_rdata(p_rdata),
    .b_valid(1'b0), .b_we(1'b0), .b_addr(8'h00), .b_wdata(8'h00),
    .b_ack(q_b_ack), .b_err(q_b_err), .b_rdata(q_b_rdata),
    .rf_write_addr(p_rf_waddr), .rf_write_data(p_rf_wdata),
    .rf_read_addr(p_rf_raddr), .rf_write(p_rf_write), .rf_read(p_rf_read),
    .rf_read_data(8'h00), .busy(p_busy)
  );

  // register-file stub: latches on the rising edge of rf_write
  logic [7:0] rf_mem [0:255];
  logic       wr_q = 1'b0;
  always @(posedge clk) begin
    if (rf_write && !wr_q) rf_mem[rf_write_addr] <= rf_write_data;
    wr_q <= rf_write;
  end
  assign rf_read_data = rf_mem[rf_read_addr];

  // reference model state
  logic [7:0] m_mem [0:255];
  logic       m_last_b = 1'b1;
  logic [7:0] m_rd_a = 8'h00;
  logic [7:0] m_rd_b = 8'h00;

  typedef struct {
    bit         port;   // 0=A, 1=B
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         lat;    // ack cycle
    bit         err;
    logic [7:0] rdata;  // own rdata at ack
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic v, input logic we,
                          input logic [7:0] ad, input logic [7:0] wd);
    if (p == 0) begin
      a_valid = v; a_we = we; a_addr = ad; a_wdata = wd;
    end else begin
      b_valid = v; b_we = we; b_addr = ad; b_wdata = wd;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit         inr;
    logic [7:0] oth_exp;
    inr     = !v.err;
    oth_exp = v.port ? m_rd_a : m_rd_b;
    set_port(int'(v.port), 1'b1, v.we, v.addr, v.wdata);
    for (int c = 0; c <= v.lat; c++) begin
      @(negedge clk);
      chk($sformatf("v%0d c%0d rf_write", idx, c), 32'(rf_write), 32'(inr && v.we && c >= 1+S && c <= S+T));
      chk($sformatf("v%0d c%0d rf_read", idx, c), 32'(rf_read), 32'(inr && !v.we && c >= 1+S && c <= S+T));
      chk($sformatf("v%0d c%0d busy", idx, c), 32'(busy), 32'(c >= 1 && c <= v.lat));
      chk($sformatf("v%0d c%0d a_ack", idx, c), 32'(a_ack), 32'(!v.port && c == v.lat));
      chk($sformatf("v%0d c%0d b_ack", idx, c), 32'(b_ack), 32'(v.port && c == v.lat));
      if (inr && c >= 1) begin
        if (v.we) begin
          chk($sformatf("v%0d c%0d waddr", idx, c), 32'(rf_write_addr), 32'(v.addr));
          chk($sformatf("v%0d c%0d wdata", idx, c), 32'(rf_write_data), 32'(v.wdata));
        end else begin
          chk($sformatf("v%0d c%0d raddr", idx, c), 32'(rf_read_addr), 32'(v.addr));
        end
      end
      if (c == v.lat) begin
        chk($sformatf("v%0d err", idx), 32'(v.port ? b_err : a_err), 32'(v.err));
        chk($sformatf("v%0d rdata", idx), 32'(v.port ? b_rdata : a_rdata), 32'(v.rdata));
        chk($sformatf("v%0d other rdata", idx), 32'(v.port ? a_rdata : b_rdata), 32'(oth_exp));
      end
      @(posedge clk); #1;
    end
    set_port(int'(v.port), 1'b0, 1'b0, 8'h00, 8'h00);
    if (v.we && inr) m_mem[v.addr] = v.wdata;
    if (v.port) m_rd_b = v.rdata; else m_rd_a = v.rdata;
    m_last_b = v.port;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  int         mode, first, second, tmax, p, lat;
  bit         oor;
  bit         use_p[2], we_p[2], err_e[2];
  logic [7:0] ad_p[2], wd_p[2];
  int         t_p[2];

  initial begin
    for (int i = 0; i < 256; i++) begin
      rf_mem[i] = 8'h00;
      m_mem[i]  = 8'h00;
    end
    //            port we  addr   wdata  lat err rdata
    vecs[0] = '{1'b0, 1'b1, 8'h03, 8'hA5, 5, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 8'h03, 8'h00, 5, 1'b0, 8'hA5};
    vecs[2] = '{1'b0, 1'b1, 8'h10, 8'h33, 1, 1'b1, 8'h00};
    vecs[3] = '{1'b0, 1'b0, 8'h20, 8'h00, 1, 1'b1, 8'h00};
    vecs[4] = '{1'b1, 1'b1, 8'h0F, 8'h5A, 5, 1'b0, 8'hA5};
    vecs[5] = '{1'b1, 1'b0, 8'h0F, 8'h00, 5, 1'b0, 8'h5A};
    vecs[6] = '{1'b0, 1'b0, 8'h03, 8'h00, 5, 1'b0, 8'hA5};

    // reset state
    @(negedge clk); @(negedge clk);
    chk("reset a", {a_ack, a_err, a_rdata}, 32'h0);
    chk("reset b", {b_ack, b_err, b_rdata}, 32'h0);
    chk("reset rf", {rf_write_addr, rf_write_data, rf_read_addr, rf_write, rf_read, busy}, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // reset during the strobe of a write
    set_port(0, 1'b1, 1'b1, 8'h05, 8'h77);
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      if (c == 2) chk("rst seq strobe up", 32'(rf_write), 32'h1);
      @(posedge clk); #1;
    end
    #2;
    reset_n = 1'b0;
    set_port(0, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    chk("rst strobe drop", {rf_write, rf_read, busy}, 32'h0);
    chk("rst outs a", {a_ack, a_err, a_rdata}, 32'h0);
    chk("rst outs b", {b_ack, b_err, b_rdata}, 32'h0);
    chk("rst outs rf", {rf_write_addr, rf_write_data, rf_read_addr}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("post-rst c%0d no ack", c), {a_ack, b_ack, busy}, 32'h0);
    end
    @(posedge clk); #1;
    m_mem[5] = 8'h77;   // the strobe edge already reached the register file
    m_last_b = 1'b1;
    m_rd_a = 8'h00;
    m_rd_b = 8'h00;

    // simultaneous requests held valid: grants A,B,A,B
    set_port(0, 1'b1, 1'b0, 8'h05, 8'h00);
    set_port(1, 1'b1, 1'b1, 8'h01, 8'h3C);
    for (int c = 0; c <= 23; c++) begin
      @(negedge clk);
      chk($sformatf("rr c%0d a_ack", c), 32'(a_ack), 32'(c == 5 || c == 17));
      chk($sformatf("rr c%0d b_ack", c), 32'(b_ack), 32'(c == 11 || c == 23));
      chk($sformatf("rr c%0d rf_read", c), 32'(rf_read), 32'((c >= 2 && c <= 3) || (c >= 14 && c <= 15)));
      chk($sformatf("rr c%0d rf_write", c), 32'(rf_write), 32'((c >= 8 && c <= 9) || (c >= 20 && c <= 21)));
      if (c == 5 || c == 17) chk($sformatf("rr c%0d a_rdata", c), {a_err, a_rdata}, 32'h077);
      if (c == 11 || c == 23) chk($sformatf("rr c%0d b_rdata", c), {b_err, b_rdata}, 32'h000);
      @(posedge clk); #1;
    end
    set_port(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_port(1, 1'b0, 1'b0, 8'h00, 8'h00);
    m_mem[1] = 8'h3C;
    m_rd_a = 8'h77;
    m_last_b = 1'b1;

    // stretched timing: setup 2, strobe 3, hold 2
    p_valid = 1'b1; p_we = 1'b1; p_addr = 8'h07; p_wdata = 8'hC3;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("p c%0d rf_write", c), 32'(p_rf_write), 32'(c >= 3 && c <= 5));
      chk($sformatf("p c%0d rf_read", c), 32'(p_rf_read), 32'h0);
      chk($sformatf("p c%0d ack", c), 32'(p_ack), 32'(c == 8));
      chk($sformatf("p c%0d busy", c), 32'(p_busy), 32'(c >= 1 && c <= 8));
      if (c >= 1 && c <= 7) chk($sformatf("p c%0d addr/data", c), {p_rf_waddr, p_rf_wdata}, 32'h07C3);
      if (c == 8) chk("p err", 32'(p_err), 32'h0);
      @(posedge clk); #1;
    end
    p_valid = 1'b0;

    // randomized rounds against the transaction model
    for (int r = 0; r < 60; r++) begin
      mode = int'($urandom_range(0, 2));
      use_p[0] = (mode != 1);
      use_p[1] = (mode != 0);
      for (int k = 0; k < 2; k++) begin
        we_p[k]  = 1'($urandom_range(0, 1));
        ad_p[k]  = 8'($urandom_range(0, 19));
        wd_p[k]  = 8'($urandom);
        t_p[k]   = -1;
        err_e[k] = 1'b0;
      end
      if (mode == 2) first = m_last_b ? 0 : 1;
      else           first = mode;
      second = 1 - first;
      tmax = 0;
      for (int k = 0; k < 2; k++) begin
        p = (k == 0) ? first : second;
        if (use_p[p]) begin
          oor = (int'(ad_p[p]) >= NREG);
          lat = oor ? 1 : 1 + S + T + H;
          t_p[p] = (k == 0) ? lat : tmax + 1 + lat;
          tmax = t_p[p];
          err_e[p] = oor;
          if (!we_p[p]) begin
            if (p == 1) m_rd_b = oor ? 8'h00 : m_mem[ad_p[p]];
            else        m_rd_a = oor ? 8'h00 : m_mem[ad_p[p]];
          end else if (!oor) begin
            m_mem[ad_p[p]] = wd_p[p];
          end
          m_last_b = (p == 1);
        end
      end
      for (int k = 0; k < 2; k++)
        if (use_p[k]) set_port(k, 1'b1, we_p[k], ad_p[k], wd_p[k]);
      for (int c = 0; c <= tmax; c++) begin
        @(negedge clk);
        chk($sformatf("r%0d c%0d a_ack", r, c), 32'(a_ack), 32'(use_p[0] && c == t_p[0]));
        chk($sformatf("r%0d c%0d b_ack", r, c), 32'(b_ack), 32'(use_p[1] && c == t_p[1]));
        chk($sformatf("r%0d c%0d strobe excl", r, c), 32'(rf_write && rf_read), 32'h0);
        if (use_p[0] && c == t_p[0]) begin
          chk($sformatf("r%0d a_err", r), 32'(a_err), 32'(err_e[0]));
          chk($sformatf("r%0d a_rdata", r), 32'(a_rdata), 32'(m_rd_a));
        end
        if (use_p[1] && c == t_p[1]) begin
          chk($sformatf("r%0d b_err", r), 32'(b_err), 32'(err_e[1]));
          chk($sformatf("r%0d b_rdata", r), 32'(b_rdata), 32'(m_rd_b));
        end
        if (c == tmax) chk($sformatf("r%0d rdata pair", r), {a_rdata, b_rdata}, {16'h0, m_rd_a, m_rd_b});
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++)
          if (use_p[k] && c == t_p[k]) set_port(k, 1'b0, 1'b0, 8'h00, 8'h00);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Arbitrates and sequences all accesses to the configuration register file between two requesters: port A (external serial config interface) and port B (on-chip calibration engine).
- The register file latches on the rising edges of its write/read strobes. This block generates those strobes as clean, glitch-free registered pulses, with address/data setup and hold around every edge.
- It also returns readback data and a per-access completion/error status to the requester that owns the access.

Parameters:
- NUMREGS, 16, number of implemented registers; addresses >= NUMREGS are rejected.
- SETUP_CYCLES, 1, clk cycles that address/data are driven before the strobe rises (>=1).
- STROBE_CYCLES, 2, clk cycles the strobe is held high (>=1).
- HOLD_CYCLES, 1, clk cycles that address/data are held after the strobe falls (>=1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- a_valid  in  1  port A request; held until a_ack
- a_we  in  1  port A: 1=write, 0=read
- a_addr  in  8  port A register address
- a_wdata  in  8  port A write data
- a_ack  out  1  port A one-cycle completion pulse
- a_err  out  1  port A error flag, valid with a_ack
- a_rdata  out  8  port A readback data, valid from a_ack until the next port A read completes
- b_valid, b_we, b_addr, b_wdata, b_ack, b_err, b_rdata: same as port A, for port B
- rf_write_addr  out  8  regfile write address
- rf_write_data  out  8  regfile write data
- rf_read_addr  out  8  regfile read address
- rf_write  out  1  regfile write strobe
- rf_read  out  1  regfile read strobe
- rf_read_data  in  8  regfile readback data
- busy  out  1  high in every state except IDLE

Behaviour:
- Output register rule: all outputs are driven directly from flops; no combinational path from any input to rf_write or rf_read.
- Reset values: every output is 0; FSM goes to IDLE; the round-robin pointer is set so that port A wins the first tie.
- Reset mid-operation: the transaction in flight is dropped, strobes fall immediately, and no ack is issued.
- FSM states: IDLE, SETUP, STROBE, HOLD, RESP.
- IDLE:
  - If either valid is high, grant a port and latch its we/addr/wdata into internal registers. Later changes on the request inputs are ignored.
  - If the latched addr >= NUMREGS, go to RESP with err=1 and rdata=0; no strobe is issued.
  - Otherwise drive rf_*_addr and rf_write_data (for a write) from the latched values and go to SETUP.
- SETUP: strobes low; stay SETUP_CYCLES cycles, then go to STROBE.
- STROBE:
  - rf_write (we=1) or rf_read (we=0) is high for exactly STROBE_CYCLES cycles; the other strobe stays low.
  - Exit to HOLD.
- HOLD:
  - Strobes low; address/data unchanged.
  - For a read, capture rf_read_data into the granted port's rdata register on the first HOLD cycle.
  - After HOLD_CYCLES cycles, go to RESP.
- RESP:
  - Pulse the granted port's ack for one cycle, with err (1 only for an out-of-range address).
  - Go to IDLE.
  - rf_*_addr and rf_write_data keep their last values until the next grant.
- Latency: a request sampled in cycle 0 gets ack in cycle 1+SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES. With defaults, ack is in cycle 5 and the next grant is sampled in cycle 6. An out-of-range request gets ack in cycle 1.
- Requester rule: valid must drop on the clock edge that ends the ack cycle. If valid is still high in IDLE, it is treated as a new request.
- Arbitration:
  - If only one valid is high, that port is granted.
  - If both are high, the port not granted last time wins (round robin).
  - The pointer updates on every grant, including out-of-range grants.
  - The losing port keeps valid high and is served next, with no starvation.
- Exclusivity: rf_write and rf_read are never high in the same cycle, and never high in two consecutive transactions without at least one low cycle between them.
- Data isolation: a port's rdata changes only on that port's own read completion. A write never changes rdata.

Test Plan:
- Port A write addr 0x03 data 0xA5, defaults -> rf_write_addr=0x03 and rf_write_data=0xA5 from cycle 1; rf_write high in cycles 2-3 only; a_ack=1 and a_err=0 in cycle 5; busy high in cycles 1-5.
- Port B read addr 0x03 after that write, regfile model returns 0xA5 -> rf_read high in cycles 2-3; b_rdata=0xA5 at b_ack; a_rdata unchanged.
- a_valid and b_valid both rise in the same cycle after reset -> A served first, B granted in the IDLE cycle after a_ack. Repeat with both held valid -> grants alternate A,B,A,B.
- Port A write addr 0x10 with NUMREGS=16 -> a_ack and a_err=1 in cycle 1; rf_write and rf_read stay 0; a_rdata=0x00 if read.
- reset_n asserted low during STROBE of a write -> rf_write falls immediately; no ack; state IDLE and all outputs 0. A new request after release completes normally.
- SETUP_CYCLES=2, STROBE_CYCLES=3, HOLD_CYCLES=2 -> strobe high for exactly 3 cycles starting in cycle 3; ack in cycle 8. Check that addr is stable from cycle 1 through cycle 7.
